// File: rtl/tx_link_sched.sv
// tx_link_sched: two-channel frame scheduler feeding an 8b/10b encoder.
//
// After reset the link sends ALIGN_LEN K28.5 commas, then idles on K28.5.
// A frame is K27.7 (SOF), the granted channel's bytes, then K29.7 (EOF).
// Frames are separated by at least IFG_LEN idle symbols. Channels are
// arbitrated two-way round-robin when a frame starts.
//
// Optional feature macro: TX_CC_EN. When defined, a clock-compensation pair
// K28.5, K28.1 is sent in IDLE after every CC_PERIOD symbols. A request that
// expires during a frame waits until after EOF.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   tx_en          permits new frames to start (never aborts a frame)
//   req_valid[1:0] per-channel byte valid
//   req_data[15:0] per-channel byte, ch0 = [7:0], ch1 = [15:8]
//   req_last[1:0]  per-channel last byte of frame
//   req_ready[1:0] per-channel byte accepted (DATA state, granted, valid)
//   enc_datain     registered encoder input {K, byte}
//   enc_dispin     running disparity to the encoder (0 = negative)
//   enc_dispout    running disparity from the encoder
//   grant[1:0]     one-hot frame owner, SOF through EOF, else 0
//   busy           high in the SOF, DATA and EOF states
//   err_underrun   pulse aligned with each mid-frame K23.7 fill symbol
//
// Handshake: a byte transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on anything but the
// state, the grant and req_valid, and is forced low while reset is high.
// Every symbol is decided from the current state and appears on enc_datain
// one cycle later, so a byte accepted in cycle N is on enc_datain in N+1.

module tx_link_sched #(
    parameter int ALIGN_LEN = 16,
    parameter int IFG_LEN   = 2,
    parameter int CC_PERIOD = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [8:0]  enc_datain,
    output logic        enc_dispin,
    input  logic        enc_dispout,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err_underrun
);

    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam logic [8:0] K27_7 = 9'h1FB;
    localparam logic [8:0] K29_7 = 9'h1FD;
    localparam logic [8:0] K23_7 = 9'h1F7;
    localparam logic [8:0] K28_1 = 9'h13C;
    localparam int AW = $clog2(ALIGN_LEN + 1);

    typedef enum logic [2:0] {
        ST_ALIGN,
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_EOF
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   align_cnt;
    logic [3:0]      ifg_cnt;     // idle symbols since EOF, saturates at 15
    logic            last_ch;     // channel granted most recently
    logic [1:0]      grant_q;
    logic            rd;
    logic            gidx;
    logic            ch_valid;
    logic            ch_last;
    logic [7:0]      ch_data;
    logic            ifg_ok;
    logic            pick;
    logic            start;
    logic            fill;
    logic [8:0]      sym;
    logic            cc_pend;
    logic            cc_phase;    // 0: K28.5 half of the pair, 1: K28.1 half

    assign gidx     = grant_q[1];
    assign ch_valid = req_valid[gidx];
    assign ch_last  = req_last[gidx];
    assign ch_data  = gidx ? req_data[15:8] : req_data[7:0];
    // The deciding IDLE cycle emits an idle symbol itself, hence IFG_LEN-1.
    assign ifg_ok   = (ifg_cnt >= 4'(IFG_LEN - 1));
    // last_ch resets to 1 so that ch0 wins the first contested arbitration.
    assign pick     = (req_valid == 2'b11) ? ~last_ch : req_valid[1];

    always_comb begin
        state_nxt = state;
        sym       = K28_5;
        start     = 1'b0;
        fill      = 1'b0;
        case (state)
            ST_ALIGN: begin
                if (align_cnt == AW'(ALIGN_LEN - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                sym = (cc_pend && cc_phase) ? K28_1 : K28_5;
                if (tx_en && ifg_ok && (|req_valid) && !cc_pend) begin
                    state_nxt = ST_SOF;
                    start     = 1'b1;
                end
            end
            ST_SOF: begin
                sym       = K27_7;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (ch_valid) begin
                    sym = {1'b0, ch_data};
                    if (ch_last) state_nxt = ST_EOF;
                end else begin
                    sym  = K23_7;
                    fill = 1'b1;
                end
            end
            ST_EOF: begin
                sym       = K29_7;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_ALIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ALIGN;
            align_cnt    <= '0;
            ifg_cnt      <= '0;
            last_ch      <= 1'b1;
            grant_q      <= 2'b00;
            enc_datain   <= K28_5;
            rd           <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_nxt;
            enc_datain   <= sym;
            rd           <= enc_dispout;
            err_underrun <= fill;
            if (state == ST_ALIGN) align_cnt <= align_cnt + 1'b1;
            // Alignment commas count as a full inter-frame gap.
            if (state == ST_ALIGN)
                ifg_cnt <= 4'hF;
            else if (state == ST_EOF)
                ifg_cnt <= '0;
            else if (state == ST_IDLE && ifg_cnt != 4'hF)
                ifg_cnt <= ifg_cnt + 1'b1;
            if (start) begin
                grant_q <= pick ? 2'b10 : 2'b01;
                last_ch <= pick;
            end else if (state == ST_EOF) begin
                grant_q <= 2'b00;
            end
        end
    end

`ifdef TX_CC_EN
    localparam int CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    logic [CW-1:0] cc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_cnt   <= '0;
            cc_pend  <= 1'b0;
            cc_phase <= 1'b0;
        end else begin
            cc_cnt <= (cc_cnt == CW'(CC_PERIOD - 1)) ? '0 : cc_cnt + 1'b1;
            if (state == ST_IDLE && cc_pend) begin
                if (cc_phase) begin
                    cc_pend  <= 1'b0;
                    cc_phase <= 1'b0;
                end else begin
                    cc_phase <= 1'b1;
                end
            end
            // A fresh expiry wins over the clear of the previous pair.
            if (cc_cnt == CW'(CC_PERIOD - 1)) cc_pend <= 1'b1;
        end
    end
`else
    assign cc_pend  = 1'b0;
    assign cc_phase = 1'b0;
`endif

    assign req_ready  = (state == ST_DATA && !reset) ? (grant_q & req_valid) : 2'b00;
    assign grant      = grant_q;
    assign busy       = (state == ST_SOF) || (state == ST_DATA) || (state == ST_EOF);
    assign enc_dispin = rd;

endmodule
